clkdiv_prog: RTL and testbench

CLKDIV_PROG -- requirements
Module: clkdiv_prog

---
 rtl/clkdiv_pkg.sv | 13 +
 rtl/clkdiv_prog_if.sv | 27 ++
 rtl/clkdiv_shadow.sv | 53 +++++
 rtl/clkdiv_prog.sv | 88 ++++++++
 tb/tb_clkdiv_prog.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/clkdiv_pkg.sv
// Shared defaults and helpers for the programmable clock divider.
// Used by clkdiv_prog, clkdiv_shadow and clkdiv_prog_if.
package clkdiv_pkg;

  localparam int CNT_W_DEF   = 8;
  localparam int DIV_RST_DEF = 4;

  // Number of low cycles in a period of n: the high phase starts at this count.
  function automatic int unsigned ceil_half(input int unsigned n);
    return (n + 1) / 2;
  endfunction

endpackage

// File: rtl/clkdiv_prog_if.sv
// Control/status bundle of the programmable clock divider.
// master drives enable and ratio requests; slave is the divider.
interface clkdiv_prog_if
  import clkdiv_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic             en;
  logic [CNT_W-1:0] div_in;
  logic             div_valid;
  logic             div_ready;
  logic             clkdiv;
  logic             tick;
  logic [CNT_W-1:0] div_cur;

  modport master (
    output en, div_in, div_valid,
    input  div_ready, clkdiv, tick, div_cur
  );

  modport slave (
    input  en, div_in, div_valid,
    output div_ready, clkdiv, tick, div_cur
  );

endinterface

// File: rtl/clkdiv_shadow.sv
// Shadow register and valid/ready handshake for divide-ratio updates.
// Holds one pending ratio until the divider consumes it via apply_i.
module clkdiv_shadow
  import clkdiv_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [CNT_W-1:0] div_in_i,
  input  logic             div_valid_i,
  input  logic             apply_i,
  output logic             div_ready_o,
  output logic             pending_o,
  output logic [CNT_W-1:0] shadow_o
);

  logic             pending_q, pending_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             take;

  // Captures are gated by en so that en=0 freezes all divider state.
  assign take = en_i & div_valid_i & ~pending_q;

  always_comb begin
    pending_d = pending_q;
    shadow_d  = shadow_q;
    if (apply_i) begin
      pending_d = 1'b0;
    end
    if (take) begin
      pending_d = 1'b1;
      // A request of 0 is stored as 1 so the counter never sees N=0.
      shadow_d  = (div_in_i == '0) ? CNT_W'(1) : div_in_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 1'b0;
      shadow_q  <= '0;
    end else begin
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
    end
  end

  assign div_ready_o = ~pending_q;
  assign pending_o   = pending_q;
  assign shadow_o    = shadow_q;

endmodule

// File: rtl/clkdiv_prog.sv
// Programmable clock divider: counter, registered square wave and wrap tick.
// Optional sync input enabled by defining CLKDIV_PROG_SYNC_EN.
module clkdiv_prog
  import clkdiv_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic         clk,
  input  logic         rst,
`ifdef CLKDIV_PROG_SYNC_EN
  input  logic         sync,
`endif
  clkdiv_prog_if.slave bus
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clkdiv_q, clkdiv_d;
  logic [CNT_W-1:0] div_cur_q, div_cur_d;
  logic [CNT_W-1:0] thr;
  logic [CNT_W-1:0] shadow;
  logic             pending;
  logic             last;
  logic             apply;
  logic             sync_w;

`ifdef CLKDIV_PROG_SYNC_EN
  assign sync_w = sync;
`else
  assign sync_w = 1'b0;
`endif

  assign last  = (cnt_q == (div_cur_q - CNT_W'(1)));
  assign thr   = CNT_W'(ceil_half(32'(div_cur_q)));
  // Pending state is registered, so a capture on a tick/sync cycle waits.
  assign apply = pending & (sync_w | (bus.en & last));

  clkdiv_shadow #(.CNT_W(CNT_W)) u_shadow (
    .clk         (clk),
    .rst         (rst),
    .en_i        (bus.en),
    .div_in_i    (bus.div_in),
    .div_valid_i (bus.div_valid),
    .apply_i     (apply),
    .div_ready_o (bus.div_ready),
    .pending_o   (pending),
    .shadow_o    (shadow)
  );

  always_comb begin
    cnt_d     = cnt_q;
    clkdiv_d  = clkdiv_q;
    div_cur_d = div_cur_q;
    if (sync_w) begin
      cnt_d    = '0;
      clkdiv_d = 1'b0;
      if (pending) begin
        div_cur_d = shadow;
      end
    end else if (bus.en) begin
      if (apply) begin
        div_cur_d = shadow;
        cnt_d     = '0;
        clkdiv_d  = 1'b0;
      end else begin
        cnt_d    = last ? '0 : cnt_q + CNT_W'(1);
        clkdiv_d = (cnt_d >= thr);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      clkdiv_q  <= 1'b0;
      div_cur_q <= CNT_W'(DIV_RST);
    end else begin
      cnt_q     <= cnt_d;
      clkdiv_q  <= clkdiv_d;
      div_cur_q <= div_cur_d;
    end
  end

  assign bus.tick    = bus.en & last & ~rst;
  assign bus.clkdiv  = clkdiv_q;
  assign bus.div_cur = div_cur_q;

endmodule

// File: tb/tb_clkdiv_prog.sv
// Self-checking bench for clkdiv_prog: directed vector table, sync corner
// cases (when CLKDIV_PROG_SYNC_EN is defined) and randomized model compare.
module tb_clkdiv_prog;

  localparam int CW  = 8;
  localparam int DRS = 4;

  logic clk;
  logic rst;
  logic sync;

  clkdiv_prog_if #(.CNT_W(CW)) bus ();

  clkdiv_prog #(.CNT_W(CW), .DIV_RST(DRS)) dut (
    .clk  (clk),
    .rst  (rst),
`ifdef CLKDIV_PROG_SYNC_EN
    .sync (sync),
`endif
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit r, e, v;
    int d;
    bit ck;
    bit ec, et, er;
    int ecur;
  } vec_t;

  vec_t vt[$];

  // Reference model: position within the current period, ratio in effect,
  // and an optional single pending ratio.
  int m_n, m_ph, m_pv;
  bit m_pend;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input bit r, e, v, input int d, input bit ck,
                     input bit ec, et, er, input int ecur);
    vec_t x;
    x.r = r; x.e = e; x.v = v; x.d = d; x.ck = ck;
    x.ec = ec; x.et = et; x.er = er; x.ecur = ecur;
    vt.push_back(x);
  endtask

  task automatic drive(input bit r, e, v, s, input int d);
    @(negedge clk);
    rst = r;
    bus.en = e;
    bus.div_valid = v;
    bus.div_in = CW'(d);
    sync = s;
    #1;
  endtask

  // Advance one clock edge and update the model from the applied inputs.
  task automatic advance();
    bit take;
    @(posedge clk);
    if (rst) begin
      m_ph = 0; m_n = DRS; m_pend = 0; m_pv = 0;
    end else begin
      take = bus.en && bus.div_valid && !m_pend;
      if (sync) begin
        m_ph = 0;
        if (m_pend) begin m_n = m_pv; m_pend = 0; end
      end else if (bus.en) begin
        if (m_ph == m_n - 1) begin
          m_ph = 0;
          if (m_pend) begin m_n = m_pv; m_pend = 0; end
        end else begin
          m_ph++;
        end
      end
      if (take) begin
        m_pend = 1;
        m_pv = (int'(bus.div_in) == 0) ? 1 : int'(bus.div_in);
      end
    end
  endtask

  task automatic chk_model();
    chk("model_tick", int'(bus.tick),
        int'(bus.en && !rst && (m_ph == m_n - 1)));
    chk("model_clkdiv", int'(bus.clkdiv), int'(m_ph >= (m_n + 1) / 2));
    chk("model_ready", int'(bus.div_ready), int'(!m_pend));
    chk("model_div_cur", int'(bus.div_cur), m_n);
  endtask

  initial begin
    rst = 1'b1; sync = 1'b0;
    bus.en = 1'b0; bus.div_valid = 1'b0; bus.div_in = '0;
    m_n = DRS; m_ph = 0; m_pv = 0; m_pend = 0;

    // Reset, then N=4 free-run: clkdiv 0,0,1,1 and tick on the 4th cycle.
    add(1,1,0,0,0,0,0,0,0);
    add(1,1,0,0,1,0,0,1,4);
    for (int k = 0; k < 8; k++) add(0,1,0,0,1,(k%4)>=2,(k%4)==3,1,4);
    // Load 5 at cnt=1; old period finishes, then 0,0,0,1,1.
    add(0,1,0,0,1,0,0,1,4);
    add(0,1,1,5,1,0,0,1,4);
    add(0,1,0,0,1,1,0,0,4);
    add(0,1,0,0,1,1,1,0,4);
    for (int k = 0; k < 5; k++) add(0,1,0,0,1,k>=3,k==4,1,5);
    // Reset, then transfer 2 on the tick cycle: applies one period later.
    add(1,1,0,0,1,0,0,1,5);
    add(0,1,0,0,1,0,0,1,4);
    add(0,1,0,0,1,0,0,1,4);
    add(0,1,0,0,1,1,0,1,4);
    add(0,1,1,2,1,1,1,1,4);
    add(0,1,0,0,1,0,0,0,4);
    add(0,1,0,0,1,0,0,0,4);
    add(0,1,0,0,1,1,0,0,4);
    add(0,1,0,0,1,1,1,0,4);
    for (int k = 0; k < 4; k++) add(0,1,0,0,1,k%2,k%2,1,2);
    // Back to 4, then freeze with en=0 at cnt=2 and at cnt=3.
    add(0,1,1,4,1,0,0,1,2);
    add(0,1,0,0,1,1,1,0,2);
    add(0,1,0,0,1,0,0,1,4);
    add(0,1,0,0,1,0,0,1,4);
    for (int k = 0; k < 3; k++) add(0,0,0,0,1,1,0,1,4);
    add(0,1,0,0,1,1,0,1,4);
    add(0,1,0,0,1,1,1,1,4);
    add(0,1,0,0,1,0,0,1,4);
    add(0,1,0,0,1,0,0,1,4);
    add(0,1,0,0,1,1,0,1,4);
    add(0,0,0,0,1,1,0,1,4);
    add(0,1,0,0,1,1,1,1,4);
    // div_in=0 becomes N=1; then div_in=1 captured on a tick.
    add(0,1,1,0,1,0,0,1,4);
    add(0,1,0,0,1,0,0,0,4);
    add(0,1,0,0,1,1,0,0,4);
    add(0,1,0,0,1,1,1,0,4);
    add(0,1,0,0,1,0,1,1,1);
    add(0,1,1,1,1,0,1,1,1);
    add(0,1,0,0,1,0,1,0,1);
    add(0,1,0,0,1,0,1,1,1);

    foreach (vt[i]) begin
      drive(vt[i].r, vt[i].e, vt[i].v, 1'b0, vt[i].d);
      chk($sformatf("vec%0d_tick", i), int'(bus.tick), int'(vt[i].et));
      if (vt[i].ck) begin
        chk($sformatf("vec%0d_clkdiv", i), int'(bus.clkdiv), int'(vt[i].ec));
        chk($sformatf("vec%0d_ready", i), int'(bus.div_ready), int'(vt[i].er));
        chk($sformatf("vec%0d_div_cur", i), int'(bus.div_cur), vt[i].ecur);
      end
      advance();
    end

`ifdef CLKDIV_PROG_SYNC_EN
    // Pending 6, sync at cnt=2: immediate apply and restart.
    drive(1,1,0,0,0); advance();
    drive(0,1,1,0,6); advance();
    drive(0,1,0,0,0); advance();
    chk("sync_pre_cnt2_clkdiv", int'(bus.clkdiv), 1);
    chk("sync_pre_ready", int'(bus.div_ready), 0);
    drive(0,1,0,1,0); advance();
    drive(0,1,0,0,0);
    chk("sync_clkdiv", int'(bus.clkdiv), 0);
    chk("sync_div_cur", int'(bus.div_cur), 6);
    chk("sync_ready", int'(bus.div_ready), 1);
    chk("sync_tick", int'(bus.tick), 0);
    advance();
    // Capture coinciding with sync stays pending.
    drive(0,1,1,1,3); advance();
    drive(0,1,0,0,0);
    chk("sync_cap_div_cur", int'(bus.div_cur), 6);
    chk("sync_cap_ready", int'(bus.div_ready), 0);
    advance();
    // Reset mid-period discards the pending ratio.
    drive(0,1,0,0,0); advance();
    drive(1,1,0,0,0); advance();
    drive(0,1,0,0,0);
    chk("rst_div_cur", int'(bus.div_cur), 4);
    chk("rst_ready", int'(bus.div_ready), 1);
    advance();
    for (int k = 0; k < 6; k++) begin drive(0,1,0,0,0); advance(); end
    drive(0,1,0,0,0);
    chk("rst_discard_div_cur", int'(bus.div_cur), 4);
    advance();
`endif

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      bit r, e, v, s;
      int d;
      r = ($urandom_range(0, 99) < 2);
      e = ($urandom_range(0, 99) < 80);
      v = e && ($urandom_range(0, 99) < 25);
`ifdef CLKDIV_PROG_SYNC_EN
      s = ($urandom_range(0, 99) < 3);
`else
      s = 1'b0;
`endif
      case ($urandom_range(0, 7))
        0: d = 0;
        1: d = 1;
        2: d = 255;
        default: d = $urandom_range(2, 12);
      endcase
      drive(r, e, v, s, d);
      chk_model();
      advance();
    end

    drive(0,0,0,0,0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
